// File: rtl/spi_pkg.sv
// Shared definitions for the SPI serial-clock engine.
//   spi_state_e : engine state encoding (IDLE, SETUP, RUN, HOLD, DONE)
//   MODE0..3    : SPI mode constants, packed as {cpol, cpha}
//   mode_cpol / mode_cpha : split a mode constant into its two config bits
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_RUN   = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } spi_state_e;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  function automatic logic mode_cpol(input logic [1:0] mode);
    return mode[1];
  endfunction

  function automatic logic mode_cpha(input logic [1:0] mode);
    return mode[0];
  endfunction

endpackage

// File: rtl/spi_sclk_engine_if.sv
// Control/status bundle of the SPI serial-clock engine.
//   start, abort         : transfer request / termination
//   cfg_cpol, cfg_cpha   : SPI mode
//   cfg_div              : half sclk period in clk cycles, minus 1
//   cfg_edges            : number of sclk edges per transfer
//   cfg_cs_dly           : cs_n setup and hold length in clk cycles
//   busy, done           : engine not idle / one-cycle completion pulse
// master modport: the requester; slave modport: the engine.
interface spi_sclk_engine_if #(
  parameter int unsigned DIV_W   = 8,
  parameter int unsigned EDGES_W = 9,
  parameter int unsigned DLY_W   = 4
);

  logic               start;
  logic               abort;
  logic               cfg_cpol;
  logic               cfg_cpha;
  logic [DIV_W-1:0]   cfg_div;
  logic [EDGES_W-1:0] cfg_edges;
  logic [DLY_W-1:0]   cfg_cs_dly;
  logic               busy;
  logic               done;

  modport master (
    output start, abort, cfg_cpol, cfg_cpha, cfg_div, cfg_edges, cfg_cs_dly,
    input  busy, done
  );

  modport slave (
    input  start, abort, cfg_cpol, cfg_cpha, cfg_div, cfg_edges, cfg_cs_dly,
    output busy, done
  );

endinterface

// File: rtl/sclk_div_cnt.sv
// Half-period counter for the sclk engine.
//   clk, rst_n : clock / asynchronous active-low reset
//   load       : clear the count to 0 (has priority over en)
//   en         : count 0..div, wrapping to 0 after div
//   div        : terminal count value
//   tc         : high while enabled and the count equals div
module sclk_div_cnt #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tc
);

  logic [DIV_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == div) ? '0 : cnt + DIV_W'(1);
    end
  end

  assign tc = en && !load && (cnt == div);

endmodule

// File: rtl/spi_sclk_engine.sv
// SPI serial-clock engine: generates cs_n framing, sclk edges and the
// data sample/shift strobes for one transfer per accepted start.
//   clk, rst_n   : clock / asynchronous active-low reset
//   ctl (slave)  : start/abort, cfg_* configuration, busy/done status
//   cs_n, sclk   : chip select and serial clock
//   lead_edge    : pulse on odd-numbered sclk edges
//   trail_edge   : pulse on even-numbered sclk edges
//   sample_stb   : data sample strobe (lead for cpha=0, trail for cpha=1)
//   shift_stb    : data shift strobe  (trail for cpha=0, lead for cpha=1)
// All outputs are registered; config is latched when start is accepted.
module spi_sclk_engine #(
  parameter int unsigned DIV_W   = 8,
  parameter int unsigned EDGES_W = 9,
  parameter int unsigned DLY_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  spi_sclk_engine_if.slave  ctl,
  output logic              cs_n,
  output logic              sclk,
  output logic              lead_edge,
  output logic              trail_edge,
  output logic              sample_stb,
  output logic              shift_stb
);

  import spi_pkg::*;

  spi_state_e         state;
  logic               cpol_q;
  logic               cpha_q;
  logic [DIV_W-1:0]   div_q;
  logic [EDGES_W-1:0] edges_q;
  logic [DLY_W-1:0]   dly_q;
  logic [DLY_W-1:0]   dly_cnt;
  logic [EDGES_W-1:0] edge_cnt;
  logic               tc;

  // Counter sits at 0 outside RUN so RUN always starts a fresh half period.
  sclk_div_cnt #(.DIV_W(DIV_W)) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (state != ST_RUN),
    .en    (state == ST_RUN),
    .div   (div_q),
    .tc    (tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      ctl.busy   <= 1'b0;
      ctl.done   <= 1'b0;
      cs_n       <= 1'b1;
      sclk       <= 1'b0;
      lead_edge  <= 1'b0;
      trail_edge <= 1'b0;
      sample_stb <= 1'b0;
      shift_stb  <= 1'b0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      div_q      <= '0;
      edges_q    <= '0;
      dly_q      <= '0;
      dly_cnt    <= '0;
      edge_cnt   <= '0;
    end else begin
      ctl.done   <= 1'b0;
      lead_edge  <= 1'b0;
      trail_edge <= 1'b0;
      sample_stb <= 1'b0;
      shift_stb  <= 1'b0;

      unique case (state)
        ST_IDLE: begin
          ctl.busy <= 1'b0;
          cs_n     <= 1'b1;
          sclk     <= ctl.cfg_cpol;
          if (ctl.start) begin
            cpol_q   <= ctl.cfg_cpol;
            cpha_q   <= ctl.cfg_cpha;
            div_q    <= ctl.cfg_div;
            edges_q  <= ctl.cfg_edges;
            dly_q    <= ctl.cfg_cs_dly;
            dly_cnt  <= ctl.cfg_cs_dly - DLY_W'(1);
            edge_cnt <= '0;
            ctl.busy <= 1'b1;
            if (ctl.cfg_cs_dly != '0) begin
              state <= ST_SETUP;
              cs_n  <= 1'b0;
            end else if (ctl.cfg_edges != '0) begin
              state <= ST_RUN;
              cs_n  <= 1'b0;
            end else begin
              state    <= ST_DONE;
              ctl.done <= 1'b1;
            end
          end
        end

        ST_SETUP: begin
          if (ctl.abort) begin
            state    <= ST_IDLE;
            ctl.busy <= 1'b0;
            cs_n     <= 1'b1;
            sclk     <= cpol_q;
          end else if (dly_cnt == '0) begin
            if (edges_q != '0) begin
              state <= ST_RUN;
            end else begin
              // No edges: go straight to the hold interval (dly_q > 0 here).
              state   <= ST_HOLD;
              dly_cnt <= dly_q - DLY_W'(1);
            end
          end else begin
            dly_cnt <= dly_cnt - DLY_W'(1);
          end
        end

        ST_RUN: begin
          if (ctl.abort) begin
            state    <= ST_IDLE;
            ctl.busy <= 1'b0;
            cs_n     <= 1'b1;
            sclk     <= cpol_q;
          end else if (tc) begin
            // edge_cnt holds edges already issued; the half period after
            // the last edge is the trailing pad before leaving RUN.
            if (edge_cnt != edges_q) begin
              sclk       <= ~sclk;
              edge_cnt   <= edge_cnt + EDGES_W'(1);
              lead_edge  <= ~edge_cnt[0];
              trail_edge <=  edge_cnt[0];
              sample_stb <= cpha_q ?  edge_cnt[0] : ~edge_cnt[0];
              shift_stb  <= cpha_q ? ~edge_cnt[0] :  edge_cnt[0];
            end else if (dly_q != '0) begin
              state   <= ST_HOLD;
              dly_cnt <= dly_q - DLY_W'(1);
            end else begin
              state    <= ST_DONE;
              ctl.done <= 1'b1;
              cs_n     <= 1'b1;
              sclk     <= cpol_q;
            end
          end
        end

        ST_HOLD: begin
          if (ctl.abort) begin
            state    <= ST_IDLE;
            ctl.busy <= 1'b0;
            cs_n     <= 1'b1;
            sclk     <= cpol_q;
          end else if (dly_cnt == '0) begin
            state    <= ST_DONE;
            ctl.done <= 1'b1;
            cs_n     <= 1'b1;
            sclk     <= cpol_q;
          end else begin
            dly_cnt <= dly_cnt - DLY_W'(1);
          end
        end

        ST_DONE: begin
          state    <= ST_IDLE;
          ctl.busy <= 1'b0;
          cs_n     <= 1'b1;
          sclk     <= ctl.cfg_cpol;
        end

        default: begin
          state    <= ST_IDLE;
          ctl.busy <= 1'b0;
          cs_n     <= 1'b1;
          sclk     <= cpol_q;
        end
      endcase
    end
  end

endmodule
